// File: rtl/jpeg_blk_buf_ctrl_pkg.sv
// Shared definitions for the JPEG coefficient block double-buffer:
// slot count, block geometry and slot-state encoding.
package jpeg_blk_buf_ctrl_pkg;
    localparam int NUM_SLOTS = 2;
    localparam int BLK_LEN   = 64;
    localparam int IDX_W     = $clog2(BLK_LEN);
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int COEF_W    = 16;
    localparam int RAM_AW    = SLOT_W + IDX_W;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_FILL,
        SLOT_FULL,
        SLOT_DRAIN
    } slot_state_e;

    // A slot takes writes and eob only while it is empty or being filled.
    function automatic logic slot_open(slot_state_e s);
        return (s == SLOT_FREE) || (s == SLOT_FILL);
    endfunction
endpackage

// File: rtl/jpeg_blk_buf_ram.sv
// Coefficient storage for both slots: one write port, one synchronous read
// port with a single cycle of read latency. Contents are never reset.
module jpeg_blk_buf_ram
    import jpeg_blk_buf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [COEF_W-1:0] wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [COEF_W-1:0] rdata
);
    logic [COEF_W-1:0] mem [NUM_SLOTS*BLK_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/jpeg_blk_buf_ctrl.sv
// Two-slot coefficient block buffer between the MCU processor and the IDCT:
// one slot fills by random-index writes while the other drains 64 beats in order.
module jpeg_blk_buf_ctrl
    import jpeg_blk_buf_ctrl_pkg::*;
#(
    parameter int ID_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              img_start_i,
    input  logic              inport_valid_i,
    input  logic [COEF_W-1:0] inport_data_i,
    input  logic [IDX_W-1:0]  inport_idx_i,
    input  logic [ID_W-1:0]   inport_id_i,
    input  logic              inport_eob_i,
    output logic              inport_blk_space_o,
    output logic              outport_valid_o,
    input  logic              outport_ready_i,
    output logic [COEF_W-1:0] outport_data_o,
    output logic [IDX_W-1:0]  outport_idx_o,
    output logic [ID_W-1:0]   outport_id_o,
    output logic              outport_last_o,
    output logic [1:0]        level_o,
    output logic              overflow_o
);
    slot_state_e          state  [NUM_SLOTS];
    logic [BLK_LEN-1:0]   bitmap [NUM_SLOTS];
    logic [ID_W-1:0]      blk_id [NUM_SLOTS];
    logic                 wr_slot, rd_slot, rd_other, rd_sel;
    logic                 out_valid, out_last, out_bit;
    logic [IDX_W-1:0]     out_idx, nxt_idx;
    logic [ID_W-1:0]      out_id;
    logic [1:0]           level;
    logic                 overflow;
    logic [COEF_W-1:0]    ram_rdata;
    logic                 wr_open, wr_en, eob_acc, accept, finish, start_cur, start_nxt;

    assign rd_other  = ~rd_slot;
    assign wr_open   = slot_open(state[wr_slot]);
    assign wr_en     = inport_valid_i && wr_open && !img_start_i;
    assign eob_acc   = inport_eob_i && wr_open;
    assign accept    = out_valid && outport_ready_i;
    assign finish    = accept && out_last;
    assign start_cur = !out_valid && (state[rd_slot] == SLOT_FULL);
    // Chain straight into the other slot on the last beat so back-to-back blocks have no bubble.
    assign start_nxt = finish && (state[rd_other] == SLOT_FULL);

    // nxt_idx/rd_sel name the beat presented after this edge; the RAM read is
    // issued for it now so its data lands with the registered beat.
    always_comb begin
        rd_sel  = rd_slot;
        nxt_idx = out_idx;
        if (start_cur) begin
            nxt_idx = '0;
        end else if (start_nxt) begin
            rd_sel  = rd_other;
            nxt_idx = '0;
        end else if (accept) begin
            nxt_idx = out_idx + IDX_W'(1);
        end
    end

    jpeg_blk_buf_ram u_ram (
        .clk   (clk_i),
        .we    (wr_en),
        .waddr ({wr_slot, inport_idx_i}),
        .wdata (inport_data_i),
        .raddr ({rd_sel, nxt_idx}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state[s]  <= SLOT_FREE;
                bitmap[s] <= '0;
                blk_id[s] <= '0;
            end
            wr_slot   <= 1'b0;
            rd_slot   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            out_bit   <= 1'b0;
            level     <= '0;
            overflow  <= 1'b0;
        end else if (img_start_i) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state[s]  <= SLOT_FREE;
                bitmap[s] <= '0;
            end
            wr_slot   <= 1'b0;
            rd_slot   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_bit   <= 1'b0;
            level     <= '0;
            overflow  <= 1'b0;
        end else begin
            if ((inport_valid_i || inport_eob_i) && !wr_open) overflow <= 1'b1;
            if (wr_en) begin
                bitmap[wr_slot][inport_idx_i] <= 1'b1;
                if (state[wr_slot] == SLOT_FREE) begin
                    state[wr_slot]  <= SLOT_FILL;
                    blk_id[wr_slot] <= inport_id_i;
                end
            end
            if (eob_acc) begin
                state[wr_slot] <= SLOT_FULL;
                if (state[wr_slot] == SLOT_FREE) blk_id[wr_slot] <= inport_id_i;
                wr_slot <= ~wr_slot;
            end
            case ({eob_acc, finish})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: ;
            endcase
            if (finish) begin
                state[rd_slot]  <= SLOT_FREE;
                bitmap[rd_slot] <= '0;
                rd_slot         <= rd_other;
            end
            if (start_cur || start_nxt) begin
                state[rd_sel] <= SLOT_DRAIN;
                out_valid     <= 1'b1;
                out_id        <= blk_id[rd_sel];
            end else if (finish) begin
                out_valid <= 1'b0;
            end
            if (start_cur || start_nxt || accept) begin
                out_idx  <= nxt_idx;
                out_last <= (nxt_idx == IDX_W'(BLK_LEN-1));
                out_bit  <= bitmap[rd_sel][nxt_idx] && !(finish && !start_nxt);
            end
        end
    end

    assign inport_blk_space_o = (state[wr_slot] == SLOT_FREE);
    assign outport_valid_o    = out_valid;
    assign outport_data_o     = out_bit ? ram_rdata : '0;
    assign outport_idx_o      = out_idx;
    assign outport_id_o       = out_id;
    assign outport_last_o     = out_last;
    assign level_o            = level;
    assign overflow_o         = overflow;
endmodule
